// File: rtl/crc_encoder_ctrl.sv
// ----------------------------------------------------------------------------
// crc_encoder_ctrl
//
// Purpose:
//   Sequences a serial CRC encoder through clear, load and SHIFT_CYCLES shift
//   cycles for one request at a time. It then captures the resulting 12-bit
//   codeword and 4-bit address into an output register that has its own
//   valid/ready handshake. Upstream logic never counts shift cycles itself.
//
// Optional feature macro:
//   CRC_CTRL_FRAME_CNT_EN - when defined, frame_cnt counts completed output
//                           handshakes and wraps modulo 256. When undefined,
//                           frame_cnt is tied to 8'h00.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   in_valid/ready    request handshake; in_data (8b) and in_addr (4b)
//   enc_clr           one-cycle encoder clear strobe (ORed into encoder rst)
//   enc_load          encoder load strobe
//   enc_shift_en      encoder shift enable, high for SHIFT_CYCLES cycles
//   enc_data/addr     held request presented to the encoder
//   enc_codeword      encoder data_out (12b)
//   enc_addr_ret      encoder addr_out (4b)
//   out_valid/ready   result handshake; out_data (12b) and out_addr (4b)
//   frame_cnt         completed-codeword counter (see macro above)
// ----------------------------------------------------------------------------
module crc_encoder_ctrl #(
  parameter int unsigned SHIFT_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic [3:0]  in_addr,
  output logic        enc_clr,
  output logic        enc_load,
  output logic        enc_shift_en,
  output logic [7:0]  enc_data,
  output logic [3:0]  enc_addr,
  input  logic [11:0] enc_codeword,
  input  logic [3:0]  enc_addr_ret,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_data,
  output logic [3:0]  out_addr,
  output logic [7:0]  frame_cnt
);

  // The counter is wide enough to hold SHIFT_CYCLES itself, so it never wraps.
  localparam int unsigned      CNT_W    = $clog2(SHIFT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_CAPTURE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q;
  logic             enc_clr_q, enc_load_q, enc_shift_q;
  logic [7:0]       hold_data_q;
  logic [3:0]       hold_addr_q;
  logic             out_valid_q;
  logic [11:0]      out_data_q;
  logic [3:0]       out_addr_q;

  logic             accept_s;
  logic             cap_load_s;
  logic             out_fire_s;
  logic             out_free_s;

  // Next-state, shift-count and handshake decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept_s   = 1'b0;
    cap_load_s = 1'b0;
    out_fire_s = out_valid_q & out_ready;
    // The output register is free if it is empty or being drained this cycle.
    out_free_s = (~out_valid_q) | out_ready;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          accept_s = 1'b1;
          state_d  = ST_CLEAR;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ST_SHIFT;
        end
      end
      ST_CAPTURE: begin
        // While stalled, all strobes are low, so the encoder holds its result.
        if (out_free_s) begin
          cap_load_s = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d    = ST_CAPTURE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, registered strobes, request holding register and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      enc_clr_q   <= 1'b0;
      enc_load_q  <= 1'b0;
      enc_shift_q <= 1'b0;
      hold_data_q <= 8'h00;
      hold_addr_q <= 4'h0;
      out_valid_q <= 1'b0;
      out_data_q  <= 12'h000;
      out_addr_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      // Strobes are decoded from the next state, so each flop is high exactly
      // while the FSM sits in the matching state.
      in_ready_q  <= (state_d == ST_IDLE);
      enc_clr_q   <= (state_d == ST_CLEAR);
      enc_load_q  <= (state_d == ST_LOAD);
      enc_shift_q <= (state_d == ST_SHIFT);
      if (accept_s) begin
        hold_data_q <= in_data;
        hold_addr_q <= in_addr;
      end
      // A reload in the same cycle as a drain wins, so out_valid stays high.
      if (cap_load_s) begin
        out_valid_q <= 1'b1;
        out_data_q  <= enc_codeword;
        out_addr_q  <= enc_addr_ret;
      end else if (out_fire_s) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef CRC_CTRL_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Completed-handshake counter, wraps modulo 256
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 8'h00;
    end else if (out_fire_s) begin
      frame_cnt_q <= frame_cnt_q + 8'h01;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 8'h00;
`endif

  assign in_ready     = in_ready_q;
  assign enc_clr      = enc_clr_q;
  assign enc_load     = enc_load_q;
  assign enc_shift_en = enc_shift_q;
  assign enc_data     = hold_data_q;
  assign enc_addr     = hold_addr_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_addr     = out_addr_q;

endmodule

// File: tb/tb_crc_encoder_ctrl.sv
// ----------------------------------------------------------------------------
// tb_crc_encoder_ctrl
//
// Self-checking bench for crc_encoder_ctrl with SHIFT_CYCLES = 12. A stub
// encoder loads the data byte into codeword[11:4] and adds one to
// codeword[3:0] on every shift. A correctly sequenced codeword is therefore
// {data, 4'(SHIFT_CYCLES)}, and the clear strobe is needed to restart the
// nibble. A scoreboard queue follows every request from accept to output
// handshake. It also tracks the value enc_data must hold and the frame
// counter.
// ----------------------------------------------------------------------------
module tb_crc_encoder_ctrl;

  localparam int unsigned S     = 12;
  localparam int          LAT   = S + 4;
  localparam logic [3:0]  S_NIB = 4'(S);

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [3:0]  in_addr;
  logic        enc_clr;
  logic        enc_load;
  logic        enc_shift_en;
  logic [7:0]  enc_data;
  logic [3:0]  enc_addr;
  logic [11:0] enc_codeword;
  logic [3:0]  enc_addr_ret;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [3:0]  out_addr;
  logic [7:0]  frame_cnt;

  crc_encoder_ctrl #(.SHIFT_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
    .enc_clr(enc_clr), .enc_load(enc_load), .enc_shift_en(enc_shift_en),
    .enc_data(enc_data), .enc_addr(enc_addr),
    .enc_codeword(enc_codeword), .enc_addr_ret(enc_addr_ret),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Stub encoder
  logic [11:0] stub_cw;
  logic [3:0]  stub_addr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_cw   <= 12'h000;
      stub_addr <= 4'h0;
    end else if (enc_clr) begin
      stub_cw   <= 12'h000;
      stub_addr <= 4'h0;
    end else if (enc_load) begin
      stub_cw   <= {enc_data, stub_cw[3:0]};
      stub_addr <= enc_addr;
    end else if (enc_shift_en) begin
      stub_cw[3:0] <= stub_cw[3:0] + 4'h1;
    end
  end
  assign enc_codeword = stub_cw;
  assign enc_addr_ret = stub_addr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct packed { logic [11:0] cw; logic [3:0] a; } exp_t;
  exp_t       sb[$];
  logic [7:0] last_d;
  logic [3:0] last_a;
  logic [7:0] exp_cnt;

  // Monitor: samples at negedge and predicts the handshakes at the next posedge
  initial begin
    last_d  = 8'h00;
    last_a  = 4'h0;
    exp_cnt = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        last_d  = 8'h00;
        last_a  = 4'h0;
        exp_cnt = 8'h00;
      end else begin
        check("enc_data_hold", enc_data, last_d);
        check("enc_addr_hold", enc_addr, last_a);
        check("frame_cnt", frame_cnt, exp_cnt);
        check("strobe_excl", ($countones({enc_clr, enc_load, enc_shift_en}) <= 1), 1);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %0h with empty scoreboard", out_data);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_data", out_data, e.cw);
            check("sb_addr", out_addr, e.a);
          end
`ifdef CRC_CTRL_FRAME_CNT_EN
          exp_cnt = exp_cnt + 8'h01;
`endif
        end
        if (in_valid && in_ready) begin
          sb.push_back({in_data, S_NIB, in_addr});
          last_d = in_data;
          last_a = in_addr;
        end
      end
    end
  end

  // Drive one request and wait (bounded) for its accept edge
  task automatic send(input logic [7:0] d, input logic [3:0] a);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_addr = a;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    check("accept_timeout", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = ~d; in_addr = ~a;
  endtask

  // Send a request and profile the strobes until out_valid rises
  task automatic do_req(input logic [7:0] d, input logic [3:0] a, output int lat,
                        output int nclr, output int nload, output int nshift,
                        output logic [7:0] ld, output logic [11:0] od, output logic [3:0] oa);
    lat = -1; nclr = 0; nload = 0; nshift = 0; ld = 8'h00; od = 12'h000; oa = 4'h0;
    send(d, a);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (enc_clr) nclr++;
      if (enc_load) begin nload++; ld = enc_data; end
      if (enc_shift_en) nshift++;
      if (out_valid) begin lat = k; od = out_data; oa = out_addr; break; end
    end
  endtask

  typedef struct { logic [7:0] d; logic [3:0] a; logic [11:0] cw; int lat; } vec_t;
  vec_t vecs[4];

  initial begin
    int lat, nclr, nload, nshift;
    logic [7:0]  ld;
    logic [11:0] od;
    logic [3:0]  oa;
    bit seen;

    vecs[0] = '{8'hA5, 4'h3, 12'hA5C, 16};
    vecs[1] = '{8'h00, 4'h0, 12'h00C, 16};
    vecs[2] = '{8'hFF, 4'hF, 12'hFFC, 16};
    vecs[3] = '{8'h5C, 4'h9, 12'h5CC, 16};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_addr = 4'h0; out_ready = 1'b1;

    // Reset values, then 20 idle cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_strobes", {enc_clr, enc_load, enc_shift_en}, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_in_ready", in_ready, 1);
      check("idle_out_valid", out_valid, 0);
      check("idle_strobes", {enc_clr, enc_load, enc_shift_en}, 0);
    end

    // Table-driven single requests with out_ready = 1
    for (int i = 0; i < 4; i++) begin
      do_req(vecs[i].d, vecs[i].a, lat, nclr, nload, nshift, ld, od, oa);
      check("vec_latency", lat, vecs[i].lat);
      check("vec_clr_cycles", nclr, 1);
      check("vec_load_cycles", nload, 1);
      check("vec_shift_cycles", nshift, S);
      check("vec_load_data", ld, vecs[i].d);
      check("vec_out_data", od, vecs[i].cw);
      check("vec_out_addr", oa, vecs[i].a);
    end
    @(posedge clk); #1;

    // Back-pressure: two requests, consumer stalled
    out_ready = 1'b0;
    do_req(8'h11, 4'h1, lat, nclr, nload, nshift, ld, od, oa);
    check("bp_first_latency", lat, LAT);
    send(8'h22, 4'h2);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, 12'h11C);
      check("bp_hold_addr", out_addr, 4'h1);
    end
    check("bp_stall_in_ready", in_ready, 0);
    check("bp_stall_strobes", {enc_clr, enc_load, enc_shift_en}, 0);
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk);
    check("bp_reload_valid", out_valid, 1);
    check("bp_reload_data", out_data, 12'h22C);
    check("bp_reload_addr", out_addr, 4'h2);
    check("bp_reload_in_ready", in_ready, 1);
    @(posedge clk); #1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_drained", out_valid, 0);

    // Busy ignore: pulse in_valid with 8'hFF during SHIFT
    send(8'h5A, 4'h6);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (enc_shift_en) begin seen = 1'b1; break; end
    end
    check("busy_reach_shift", seen, 1);
    @(posedge clk); #1; in_valid = 1'b1; in_data = 8'hFF; in_addr = 4'hF;
    @(negedge clk);
    check("busy_in_ready", in_ready, 0);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    check("busy_enc_data", enc_data, 8'h5A);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    check("busy_done", seen, 1);
    check("busy_out_data", out_data, 12'h5AC);
    check("busy_out_addr", out_addr, 4'h6);
    repeat (20) @(negedge clk);
    check("busy_no_dup", out_valid, 0);
    check("busy_sb_empty", sb.size(), 0);

    // Mid-operation reset at shift count 5
    send(8'h3C, 4'h9);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (enc_shift_en) begin seen = 1'b1; break; end
    end
    check("mrst_reach_shift", seen, 1);
    repeat (5) @(negedge clk);
    #2; rst = 1'b1; #1;
    check("mrst_strobes", {enc_clr, enc_load, enc_shift_en}, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_enc_data", {enc_data, enc_addr}, 0);
    check("mrst_out", {out_data, out_addr}, 0);
    check("mrst_frame_cnt", frame_cnt, 0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    do_req(8'h77, 4'h7, lat, nclr, nload, nshift, ld, od, oa);
    check("mrst_next_latency", lat, LAT);
    check("mrst_next_data", od, 12'h77C);
    check("mrst_next_shift", nshift, S);

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) == 0);
      in_data   = 8'($urandom);
      in_addr   = 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(negedge clk);
    check("rand_drained", sb.size(), 0);
    check("rand_out_valid", out_valid, 0);

    // Frame counter: 257 handshakes from a fresh reset
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    for (int i = 0; i < 257; i++) begin
      do_req(8'($urandom), 4'($urandom), lat, nclr, nload, nshift, ld, od, oa);
    end
    repeat (2) @(negedge clk);
`ifdef CRC_CTRL_FRAME_CNT_EN
    check("frame_cnt_257", frame_cnt, 8'h01);
`else
    check("frame_cnt_257", frame_cnt, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
